arb2_rr_mux: RTL

ARB2_RR_MUX -- requirements
Module: arb2_rr_mux

---
 rtl/arb2_pkg.sv | 19 +
 rtl/arb2_rr_grant.sv | 31 +++
 rtl/arb2_rr_mux.sv | 129 ++++++++++++
 3 files changed

// File: rtl/arb2_pkg.sv
// Shared constants and types for the two-source round-robin output register.
package arb2_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int unsigned STAT_W = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/arb2_rr_grant.sv
// Two-way round-robin grant: a tie goes to the source not granted last time.
module arb2_rr_grant
    import arb2_pkg::*;
(
    input  logic a_valid_i,
    input  logic b_valid_i,
    input  logic last_sel_i,
    input  logic can_accept_i,
    output logic grant_a_o,
    output logic grant_b_o
);

    always_comb begin
        grant_a_o = 1'b0;
        grant_b_o = 1'b0;
        if (can_accept_i) begin
            if (a_valid_i && b_valid_i) begin
                if (last_sel_i == SEL_A) begin
                    grant_b_o = 1'b1;
                end else begin
                    grant_a_o = 1'b1;
                end
            end else if (a_valid_i) begin
                grant_a_o = 1'b1;
            end else if (b_valid_i) begin
                grant_b_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb2_rr_mux.sv
// Round-robin 2:1 merge into a single output register with full-rate reload.
// Optional per-source grant counters are enabled by defining ARB2_STATS_EN.
module arb2_rr_mux
    import arb2_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sel,
    input  logic              out_ready
`ifdef ARB2_STATS_EN
    ,
    output logic [STAT_W-1:0] cnt_a,
    output logic [STAT_W-1:0] cnt_b
`endif
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              sel_q, sel_d;
    logic              last_sel_q, last_sel_d;

    logic              can_accept;
    logic              grant_en;
    logic              grant_a;
    logic              grant_b;
    logic              granted;
    logic [DATA_W-1:0] mux_data;

    assign can_accept = (state_q == ST_EMPTY) || out_ready;
    // Readies must stay low while reset is held, independent of state.
    assign grant_en   = can_accept && rst_n;

    arb2_rr_grant u_grant (
        .a_valid_i    (a_valid),
        .b_valid_i    (b_valid),
        .last_sel_i   (last_sel_q),
        .can_accept_i (grant_en),
        .grant_a_o    (grant_a),
        .grant_b_o    (grant_b)
    );

    assign granted  = grant_a || grant_b;
    assign mux_data = grant_b ? b_data : a_data;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        sel_d      = sel_q;
        last_sel_d = last_sel_q;
        case (state_q)
            ST_EMPTY: begin
                if (granted) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready && !granted) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (granted) begin
            data_d     = mux_data;
            sel_d      = grant_b ? SEL_B : SEL_A;
            last_sel_d = grant_b ? SEL_B : SEL_A;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            data_q     <= '0;
            sel_q      <= SEL_A;
            last_sel_q <= SEL_B;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            last_sel_q <= last_sel_d;
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

`ifdef ARB2_STATS_EN
    logic [STAT_W-1:0] cnt_a_q, cnt_a_d;
    logic [STAT_W-1:0] cnt_b_q, cnt_b_d;

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (grant_a) begin
            cnt_a_d = sat_inc(cnt_a_q);
        end
        if (grant_b) begin
            cnt_b_d = sat_inc(cnt_b_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`endif

endmodule
